// File: rtl/opcodes.sv
// Shared opcode and phase encodings for the sequencer and its datapath.
// Pure type/function package; no state.
package opcodes;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller_seq_if.sv
// Control bundle between the instruction sequencer (master) and the datapath (slave).
// Carries the decoded opcode/flags in and the per-phase strobes out.
interface controller_seq_if #(
    parameter int CNT_W = 16
);
    import opcodes::*;

    opcode_t            opcode;
    logic               zero;
    logic               mem_ready;

    logic               mem_rd;
    logic               load_ir;
    logic               inc_pc;
    logic               load_pc;
    logic               load_ac;
    logic               mem_wr;
    logic               halt;
    phase_t             phase;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr,
        output halt, phase, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr,
        input  halt, phase, instr_count
    );

endinterface

// File: rtl/controller_seq.sv
// Eight-phase instruction sequencer: decodes (phase, opcode, zero) into datapath strobes.
// Latency: outputs are combinational from the phase register; 8 clks per unstalled instruction.
// Backpressure: stalls in INST_FETCH (always) and OP_FETCH (ALU ops) until mem_ready.
module controller_seq
    import opcodes::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    controller_seq_if.master   bus
);

    phase_t             phase_q;
    phase_t             phase_d;
    logic               halted_q;
    logic               halted_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               aluop;

    assign aluop = is_aluop(bus.opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Once halted, the phase parks in OP_ADDR and nothing advances until rst.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (!halted_q) begin
            unique case (phase_q)
                INST_ADDR:  phase_d = INST_FETCH;
                INST_FETCH: if (bus.mem_ready) phase_d = INST_LOAD;
                INST_LOAD:  phase_d = IDLE;
                IDLE:       phase_d = OP_ADDR;
                OP_ADDR: begin
                    if (bus.opcode == HLT) halted_d = 1'b1;
                    else                   phase_d  = OP_FETCH;
                end
                OP_FETCH:   if (!aluop || bus.mem_ready) phase_d = ALU_OP;
                ALU_OP:     phase_d = STORE;
                STORE: begin
                    phase_d = INST_ADDR;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default:    phase_d = INST_ADDR;
            endcase
        end
    end

    always_comb begin
        bus.mem_rd  = 1'b0;
        bus.load_ir = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.load_pc = 1'b0;
        bus.load_ac = 1'b0;
        bus.mem_wr  = 1'b0;
        unique case (phase_q)
            INST_ADDR: ;
            INST_FETCH: bus.mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                bus.mem_rd  = 1'b1;
                bus.load_ir = 1'b1;
            end
            // The HLT cycle itself still bumps the PC; only the parked state is silent.
            OP_ADDR:    bus.inc_pc = !halted_q;
            OP_FETCH:   bus.mem_rd = aluop;
            ALU_OP: begin
                bus.mem_rd  = aluop;
                bus.inc_pc  = (bus.opcode == SKZ) && bus.zero;
                bus.load_pc = (bus.opcode == JMP);
            end
            STORE: begin
                bus.mem_rd  = aluop;
                bus.inc_pc  = (bus.opcode == JMP);
                bus.load_pc = (bus.opcode == JMP);
                bus.load_ac = aluop;
                bus.mem_wr  = (bus.opcode == STO);
            end
            default: ;
        endcase
    end

    assign bus.halt        = halted_q;
    assign bus.phase       = phase_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_controller_seq.sv
// Scoreboard bench for controller_seq: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_controller_seq;
    import opcodes::*;

    localparam int CW = 4;

    typedef struct {
        phase_t          ph;
        logic [5:0]      str;
        logic            h;
        logic [CW-1:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controller_seq_if #(.CNT_W(CW)) bus();

    controller_seq #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    opcode_t       cur_op = ADD;
    logic          cur_z  = 1'b0;
    logic [CW-1:0] cnt    = '0;

    // Strobe order: {mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr}
    function automatic logic [5:0] exp_str(input phase_t ph, input opcode_t op,
                                           input logic z, input logic h);
        logic a;
        logic [5:0] s;
        a = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        s = 6'b000000;
        case (ph)
            INST_FETCH: s = 6'b100000;
            INST_LOAD:  s = 6'b110000;
            IDLE:       s = 6'b110000;
            OP_ADDR:    s = 6'b001000;
            OP_FETCH:   s = {a, 5'b00000};
            ALU_OP:     s = {a, 1'b0, (op == SKZ) && z, op == JMP, 2'b00};
            STORE:      s = {a, 1'b0, op == JMP, op == JMP, a, op == STO};
            default:    s = 6'b000000;
        endcase
        if (h) s = 6'b000000;
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("phase", int'(bus.phase), int'(e.ph));
            chk("strobes", int'({bus.mem_rd, bus.load_ir, bus.inc_pc,
                                 bus.load_pc, bus.load_ac, bus.mem_wr}), int'(e.str));
            chk("halt", int'(bus.halt), int'(e.h));
            chk("instr_count", int'(bus.instr_count), int'(e.cnt));
        end
    end

    // One clock: drive inputs just after the edge and queue what this cycle must show.
    task automatic cyc(input logic r, input logic mr, input phase_t ph, input logic h);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.mem_ready = mr;
        bus.opcode    = cur_op;
        bus.zero      = cur_z;
        e.ph  = ph;
        e.str = exp_str(ph, cur_op, cur_z, h);
        e.h   = h;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // mem_ready is driven high in non-wait phases to show it has no effect there.
    task automatic run_instr(input opcode_t op, input logic z, input int if_st, input int of_st);
        cur_op = op;
        cur_z  = z;
        cyc(1'b0, 1'b1, INST_ADDR, 1'b0);
        repeat (if_st) cyc(1'b0, 1'b0, INST_FETCH, 1'b0);
        cyc(1'b0, 1'b1, INST_FETCH, 1'b0);
        cyc(1'b0, 1'b1, INST_LOAD, 1'b0);
        cyc(1'b0, 1'b0, IDLE, 1'b0);
        cyc(1'b0, 1'b1, OP_ADDR, 1'b0);
        if (op == HLT) return;
        if ((op == ADD) || (op == AND) || (op == XOR) || (op == LDA)) begin
            repeat (of_st) cyc(1'b0, 1'b0, OP_FETCH, 1'b0);
            cyc(1'b0, 1'b1, OP_FETCH, 1'b0);
        end else begin
            cyc(1'b0, 1'b0, OP_FETCH, 1'b0);
        end
        cyc(1'b0, 1'b1, ALU_OP, 1'b0);
        cyc(1'b0, 1'b1, STORE, 1'b0);
        cnt = cnt + 1'b1;
    endtask

    initial begin
        bus.opcode    = ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        cyc(1'b1, 1'b0, INST_ADDR, 1'b0);
        cyc(1'b1, 1'b1, INST_ADDR, 1'b0);

        run_instr(ADD, 1'b0, 0, 0);
        run_instr(LDA, 1'b0, 1, 3);
        run_instr(SKZ, 1'b1, 0, 0);
        run_instr(SKZ, 1'b0, 0, 0);
        run_instr(JMP, 1'b1, 0, 0);
        run_instr(STO, 1'b0, 0, 0);
        run_instr(XOR, 1'b1, 0, 1);
        run_instr(AND, 1'b0, 2, 0);

        // Reset lands while INST_FETCH is stalled and mem_ready is just arriving.
        cur_op = ADD;
        cur_z  = 1'b0;
        cyc(1'b0, 1'b1, INST_ADDR, 1'b0);
        cyc(1'b0, 1'b0, INST_FETCH, 1'b0);
        cyc(1'b0, 1'b0, INST_FETCH, 1'b0);
        cyc(1'b1, 1'b1, INST_FETCH, 1'b0);
        cnt = '0;
        run_instr(ADD, 1'b0, 2, 0);

        // 16 more ADDs after one already retired: count walks through 15 -> 0 -> 1.
        for (int i = 0; i < 16; i++) run_instr(ADD, 1'b0, 0, 0);

        run_instr(HLT, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i & 1), OP_ADDR, 1'b1);
        cyc(1'b1, 1'b1, OP_ADDR, 1'b1);
        cnt = '0;
        cyc(1'b0, 1'b1, INST_ADDR, 1'b0);
        cyc(1'b0, 1'b0, INST_FETCH, 1'b0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
